// File: rtl/pc_unit.sv
// Program counter with next-PC select, link address and interrupt request latch.
// Optional macro PC_UNIT_IRQ_SYNC_EN adds a two-flop synchronizer on irq_in.
//
// state   | meaning
// IDLE    | no interrupt pending
// PENDING | edge seen on irq_in, waiting for decoder to take it
module pc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        ALUOut0,
  input  logic [31:0] ExtImm,
  input  logic [25:0] JT,
  input  logic [31:0] DataBusA,
  input  logic        irq_in,
  output logic [31:0] PC,
  output logic        PC31,
  output logic        IRQ,
  output logic [31:0] LinkAddr
);

  typedef enum logic {IDLE, PENDING} irq_state_t;

  irq_state_t  state, state_nxt;
  logic [31:0] pc_q, pc_nxt, pc_plus4, br_target;
  logic [30:0] br_off;
  logic        sync_q, prev_q, rise;
  logic        unused_bits;

  assign unused_bits = ^{ExtImm[31:29], DataBusA[1:0]};

`ifdef PC_UNIT_IRQ_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign sync_q = sync2_q;
`else
  assign sync_q = irq_in;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sync_q;
  end

  assign rise = sync_q & ~prev_q;

  // Bit 31 is the supervisor flag; the increment and branch adders are 31 bits wide.
  assign pc_plus4  = {pc_q[31], pc_q[30:0] + 31'd4};
  assign br_off    = {ExtImm[28:0], 2'b00};
  assign br_target = {pc_q[31], pc_plus4[30:0] + br_off};

  always_comb begin
    pc_nxt = pc_plus4;
    case (PCSrc)
      3'd1:    pc_nxt = ALUOut0 ? br_target : pc_plus4;
      3'd2:    pc_nxt = {pc_q[31:28], JT, 2'b00};
      3'd3:    pc_nxt = {DataBusA[31:2], 2'b00};
      3'd4:    pc_nxt = 32'h8000_0004;
      3'd5:    pc_nxt = 32'h8000_0008;
      default: pc_nxt = pc_plus4;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= 32'h8000_0000;
    else       pc_q <= pc_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // A new edge arriving on the same cycle the interrupt is taken keeps it pending.
  always_comb begin
    state_nxt = state;
    IRQ       = (state == PENDING) & ~pc_q[31];
    case (state)
      IDLE:    if (rise) state_nxt = PENDING;
      PENDING: if (IRQ && !rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign PC       = pc_q;
  assign PC31     = pc_q[31];
  // On interrupt the return address is the interrupted instruction itself.
  assign LinkAddr = IRQ ? pc_q : pc_plus4;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: expected PC/IRQ are queued when a step is driven
// and compared after the following clock edge.
module tb_pc_unit;

`ifdef PC_UNIT_IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  pcsrc = 3'd0;
  logic        aluout0 = 1'b0;
  logic [31:0] extimm = 32'd0;
  logic [25:0] jt = 26'd0;
  logic [31:0] databusa = 32'd0;
  logic        irq_in = 1'b0;
  logic [31:0] pc;
  logic        pc31;
  logic        irq;
  logic [31:0] linkaddr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic        irq;
    string       tag;
  } exp_t;

  exp_t sb[$];

  pc_unit dut (
    .clk(clk), .reset(reset), .PCSrc(pcsrc), .ALUOut0(aluout0), .ExtImm(extimm),
    .JT(jt), .DataBusA(databusa), .irq_in(irq_in), .PC(pc), .PC31(pc31),
    .IRQ(irq), .LinkAddr(linkaddr)
  );

  always #5 clk = ~clk;

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty: got size 0 want >0");
      return;
    end
    e = sb.pop_front();
    checks++;
    assert (pc === e.pc) else begin
      errors++;
      $error("FAIL %s pc: got %h want %h", e.tag, pc, e.pc);
    end
    checks++;
    assert (pc31 === e.pc[31]) else begin
      errors++;
      $error("FAIL %s pc31: got %b want %b", e.tag, pc31, e.pc[31]);
    end
    checks++;
    assert (irq === e.irq) else begin
      errors++;
      $error("FAIL %s irq: got %b want %b", e.tag, irq, e.irq);
    end
  endtask

  task automatic check_now(input logic [31:0] epc, input logic eirq, input string tag);
    exp_t e;
    e.pc = epc; e.irq = eirq; e.tag = tag;
    sb.push_back(e);
    check_out();
  endtask

  task automatic check_link(input logic [31:0] exp_link, input string tag);
    checks++;
    assert (linkaddr === exp_link) else begin
      errors++;
      $error("FAIL %s linkaddr: got %h want %h", tag, linkaddr, exp_link);
    end
  endtask

  task automatic step(input logic [2:0] src, input logic alu, input logic [31:0] ext,
                      input logic [25:0] j, input logic [31:0] dba, input logic irqv,
                      input logic [31:0] epc, input logic eirq, input string tag);
    exp_t e;
    pcsrc = src; aluout0 = alu; extimm = ext; jt = j; databusa = dba; irq_in = irqv;
    e.pc = epc; e.irq = eirq; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // reset state and sequential fetch
    #12;
    check_now(32'h8000_0000, 1'b0, "reset");
    check_link(32'h8000_0004, "reset_link");
    reset = 1'b0;
    step(3'd0, 0, 0, 0, 0, 0, 32'h8000_0004, 0, "seq1");
    step(3'd0, 0, 0, 0, 0, 0, 32'h8000_0008, 0, "seq2");
    step(3'd0, 0, 0, 0, 0, 0, 32'h8000_000C, 0, "seq3");
    step(3'd6, 0, 0, 0, 0, 0, 32'h8000_0010, 0, "rsv6");

    // register and jump paths
    step(3'd3, 0, 0, 0, 32'h0040_0003, 0, 32'h0040_0000, 0, "jr_user");
    step(3'd2, 0, 0, 26'h000_0010, 0, 0, 32'h0000_0040, 0, "jump");

    // branch taken / not taken with negative offset
    step(3'd3, 0, 0, 0, 32'h0000_0100, 0, 32'h0000_0100, 0, "jr_100a");
    step(3'd1, 1, 32'hFFFF_FFFE, 0, 0, 0, 32'h0000_00FC, 0, "br_taken");
    step(3'd3, 0, 0, 0, 32'h0000_0100, 0, 32'h0000_0100, 0, "jr_100b");
    step(3'd1, 0, 32'hFFFF_FFFE, 0, 0, 0, 32'h0000_0104, 0, "br_not");

    // interrupt in user space
    step(3'd3, 0, 0, 0, 32'h0000_0200, 0, 32'h0000_0200, 0, "jr_200");
    check_link(32'h0000_0204, "link_seq");
    for (int k = 1; k <= LAT; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0200, logic'(k == 1), 32'h0000_0200, logic'(k == LAT), "irq_lat");
    check_link(32'h0000_0200, "link_irq");
    step(3'd4, 0, 0, 0, 0, 0, 32'h8000_0004, 0, "take_irq");

    // masked in supervisor, delivered after return to user space
    step(3'd0, 0, 0, 0, 0, 1, 32'h8000_0008, 0, "sup_pulse");
    for (int k = 0; k < LAT + 1; k++)
      step(3'd0, 0, 0, 0, 0, 0, 32'h8000_000C + 32'(4 * k), 0, "sup_masked");
    step(3'd3, 0, 0, 0, 32'h0000_0300, 0, 32'h0000_0300, 1, "jr_300_irq");
    step(3'd4, 0, 0, 0, 0, 0, 32'h8000_0004, 0, "take_irq2");

    // level held high yields one event; re-arm after low
    step(3'd3, 0, 0, 0, 32'h0000_0400, 0, 32'h0000_0400, 0, "jr_400");
    for (int k = 1; k <= LAT; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0400, 1, 32'h0000_0400, logic'(k == LAT), "lvl_lat");
    step(3'd4, 0, 0, 0, 0, 1, 32'h8000_0004, 0, "take_lvl");
    for (int k = 0; k < 4; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0400, 1, 32'h0000_0400, 0, "lvl_once");
    for (int k = 0; k < 4; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0400, 0, 32'h0000_0400, 0, "lvl_low");
    for (int k = 1; k <= LAT; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0400, 1, 32'h0000_0400, logic'(k == LAT), "rearm");

    // asynchronous reset with interrupt pending
    #3;
    reset = 1'b1;
    #1;
    check_now(32'h8000_0000, 1'b0, "rst_async");
    check_link(32'h8000_0004, "rst_link");
    irq_in = 1'b0;
    pcsrc = 3'd0;
    #8;
    reset = 1'b0;
    step(3'd0, 0, 0, 0, 0, 0, 32'h8000_0004, 0, "post_rst");
    step(3'd3, 0, 0, 0, 32'h0000_0500, 0, 32'h0000_0500, 0, "jr_500");
    for (int k = 0; k < 4; k++)
      step(3'd3, 0, 0, 0, 32'h0000_0500, 0, 32'h0000_0500, 0, "no_stale_irq");

    // boundaries: 31-bit wrap, supervisor-preserving branch/jump, vectors
    step(3'd3, 0, 0, 0, 32'h7FFF_FFFC, 0, 32'h7FFF_FFFC, 0, "jr_top_user");
    step(3'd0, 0, 0, 0, 0, 0, 32'h0000_0000, 0, "wrap_user");
    step(3'd3, 0, 0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 0, "jr_top_sup");
    step(3'd7, 0, 0, 0, 0, 0, 32'h8000_0000, 0, "wrap_sup_rsv7");
    step(3'd3, 0, 0, 0, 32'hFFFF_FFF0, 0, 32'hFFFF_FFF0, 0, "jr_fff0");
    step(3'd1, 1, 32'h0000_0004, 0, 0, 0, 32'h8000_0004, 0, "br_wrap_sup");
    step(3'd2, 0, 0, 26'h3FF_FFFF, 0, 0, 32'h8FFF_FFFC, 0, "jump_sup");
    step(3'd5, 0, 0, 0, 0, 0, 32'h8000_0008, 0, "exc_vec");
    step(3'd1, 0, 32'h0000_0040, 0, 0, 0, 32'h8000_000C, 0, "br_not_sup");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
